mem_port_arbiter: RTL

Shares one single-port synchronous memory between the instruction-fetch stage and the load/store (MEM) stage of the RISC-V core. Each requester uses a req/ack handshake. The arbiter picks one winner, drives the memory port, and returns read data with a one-cycle ack pulse. It sits between the pipeline stages and the unified program/data memory inside riscv_top.

---
 rtl/riscv_mem_pkg.sv | 17 +
 rtl/mem_port_arbiter.sv | 118 +++++++++++
 2 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the unified memory port.
// Holds the arbiter state encoding and the default bus widths.
package riscv_mem_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 32;
   localparam int ARB_LAT    = 3;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE_IF,
      ISSUE_DM,
      RESP_IF,
      RESP_DM
   } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Fetch / load-store arbiter for the single-port program/data memory.
// Optional fetch anti-starvation limit: define ARB_FAIRNESS_EN.
module mem_port_arbiter
   import riscv_mem_pkg::*;
#(
   parameter int ADDR_W        = ADDR_W_DEF,
   parameter int DATA_W        = DATA_W_DEF,
   parameter int DM_STREAK_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_ack,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   arb_state_t        state;
   arb_state_t        state_nx;
   logic              en_nx;
   logic              we_nx;
   logic [ADDR_W-1:0] addr_nx;
   logic [DATA_W-1:0] wdata_nx;
   logic              dm_win;

`ifdef ARB_FAIRNESS_EN
   localparam int STREAK_W = $clog2(DM_STREAK_MAX + 1);
   localparam logic [STREAK_W-1:0] STREAK_TOP =
      STREAK_W'(DM_STREAK_MAX);

   logic [STREAK_W-1:0] streak;
   logic                if_starved;

   assign if_starved = if_req && (streak == STREAK_TOP);
   assign dm_win     = dm_req && !if_starved;

   // Count data grants that bypass a waiting fetch; any fetch grant clears.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         streak <= '0;
      end else if (state == IDLE) begin
         if (if_req && !dm_win)
            streak <= '0;
         else if (dm_win && if_req && streak != STREAK_TOP)
            streak <= streak + 1'b1;
      end
   end
`else
   assign dm_win = dm_req;

   // Strict data priority: the streak limit has no effect in this build.
   if (DM_STREAK_MAX < 1) begin : g_streak_ignored
   end
`endif

   // State register and registered memory port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         state     <= state_nx;
         mem_en    <= en_nx;
         mem_we    <= we_nx;
         mem_addr  <= addr_nx;
         mem_wdata <= wdata_nx;
      end
   end

   // Grant in IDLE, then walk ISSUE -> RESP -> IDLE with no shortcuts.
   always_comb begin
      state_nx = state;
      en_nx    = 1'b0;
      we_nx    = 1'b0;
      addr_nx  = mem_addr;
      wdata_nx = mem_wdata;
      unique case (state)
         IDLE: begin
            if (dm_win) begin
               state_nx = ISSUE_DM;
               en_nx    = 1'b1;
               we_nx    = dm_we;
               addr_nx  = dm_addr;
               wdata_nx = dm_wdata;
            end else if (if_req) begin
               state_nx = ISSUE_IF;
               en_nx    = 1'b1;
               addr_nx  = if_addr;
            end
         end
         ISSUE_IF: state_nx = RESP_IF;
         ISSUE_DM: state_nx = RESP_DM;
         RESP_IF:  state_nx = IDLE;
         RESP_DM:  state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   assign if_ack   = (state == RESP_IF);
   assign dm_ack   = (state == RESP_DM);
   assign if_rdata = mem_rdata;
   assign dm_rdata = mem_rdata;

endmodule
